popcount_accum: RTL and testbench

Pipelined, parametrised population-count accumulator built from a layer of 5:3 bit counters. Each accepted N-bit word is reduced to its ones-count, and a running per-frame total is kept. Sits behind bit-serial/bit-vector datapaths (syndrome weight, match-vector scoring) that need a streaming ones-count rather than a single combinational 5:3 count.

---
 rtl/popcount_pkg.sv | 17 +
 rtl/counter_5to3.sv | 17 +
 rtl/popcount_accum.sv | 114 +++++++++++
 tb/tb_popcount_accum.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// Shared constants and sizing helpers for the popcount accumulator slice.
// Build option POPCOUNT_ACCUM_SAT_EN is consumed by popcount_accum.sv.
package popcount_pkg;

  localparam int GROUP_W = 5;

  // Number of 5-bit groups needed to cover an n-bit word (zero padded).
  function automatic int group_count(input int n);
    return (n + GROUP_W - 1) / GROUP_W;
  endfunction

  // Width needed to hold a ones-count of 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/counter_5to3.sv
// Combinational 5:3 counter: ones-count of five bits as cnt = {cout, carry, sum}.
module counter_5to3 (
  input  logic [4:0] bits,
  output logic [2:0] cnt
);

  logic s_a, c_a, s_b, c_b;

  // Two full adders give a weight-1 sum and two weight-2 carries.
  assign s_a = bits[0] ^ bits[1] ^ bits[2];
  assign c_a = (bits[0] & bits[1]) | (bits[0] & bits[2]) | (bits[1] & bits[2]);
  assign s_b = s_a ^ bits[3] ^ bits[4];
  assign c_b = (s_a & bits[3]) | (s_a & bits[4]) | (bits[3] & bits[4]);

  assign cnt = {c_a & c_b, c_a ^ c_b, s_b};

endmodule

// File: rtl/popcount_accum.sv
// Two-stage streaming popcount with per-frame running total and sticky overflow.
// Define POPCOUNT_ACCUM_SAT_EN to saturate out_acc instead of wrapping.
module popcount_accum
  import popcount_pkg::*;
#(
  parameter int N     = 15,
  parameter int ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0]            in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(N+1)-1:0]  out_cnt,
  output logic [ACC_W-1:0]        out_acc,
  output logic                    out_last,
  output logic                    out_ovf
);

  localparam int G     = group_count(N);
  localparam int CNT_W = cnt_width(N);
  localparam int PAD_W = G * GROUP_W;

  // Handshake: a word moves on a rising edge only when valid && ready are both
  // high on that side; producers hold data stable while valid && !ready, and
  // ready may depend combinationally on the downstream ready (never on valid).
  logic s1_valid, s1_last;
  logic [G-1:0][2:0] grp_cnt, s1_cnt;
  logic s2_adv, s1_adv, in_fire;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv && !rst && !clr;
  assign in_fire  = in_valid && in_ready;

  logic [PAD_W-1:0] padded;
  assign padded = PAD_W'(in_data);

  for (genvar g = 0; g < G; g++) begin : g_cnt
    counter_5to3 u_cnt (
      .bits (padded[g*GROUP_W +: GROUP_W]),
      .cnt  (grp_cnt[g])
    );
  end

  logic [CNT_W-1:0] word_cnt;
  always_comb begin
    word_cnt = '0;
    for (int g = 0; g < G; g++) begin
      word_cnt = word_cnt + CNT_W'(s1_cnt[g]);
    end
  end

  // Running total of the open frame; cleared when a last word enters S2,
  // which is exactly the word after which the next frame starts at zero.
  logic [ACC_W-1:0] tot_q, new_tot;
  logic             ovf_q, new_ovf;
  logic [ACC_W:0]   sum_ext;

  assign sum_ext = {1'b0, tot_q} + (ACC_W+1)'(word_cnt);
  assign new_ovf = ovf_q | sum_ext[ACC_W];

`ifdef POPCOUNT_ACCUM_SAT_EN
  assign new_tot = new_ovf ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign new_tot = sum_ext[ACC_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_cnt    <= '0;
      out_valid <= 1'b0;
      out_cnt   <= '0;
      out_acc   <= '0;
      out_last  <= 1'b0;
      out_ovf   <= 1'b0;
      tot_q     <= '0;
      ovf_q     <= 1'b0;
    end else if (clr) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
      tot_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_fire;
        if (in_fire) begin
          s1_cnt  <= grp_cnt;
          s1_last <= in_last;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_cnt  <= word_cnt;
          out_acc  <= new_tot;
          out_ovf  <= new_ovf;
          out_last <= s1_last;
          tot_q    <= s1_last ? '0 : new_tot;
          ovf_q    <= s1_last ? 1'b0 : new_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_popcount_accum.sv
// Bench for popcount_accum: a 16-bit and an 8-bit accumulator driven in lockstep
// and scored against a frame-total model built from $countones and integer math.
module tb_popcount_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic [14:0] in_data = '0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;

  logic in_ready16, out_valid16, out_last16, out_ovf16;
  logic [3:0] out_cnt16;
  logic [15:0] out_acc16;
  logic in_ready8, out_valid8, out_last8, out_ovf8;
  logic [3:0] out_cnt8;
  logic [7:0] out_acc8;

  always #5 clk = ~clk;

  popcount_accum #(.N(15), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready16),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid16), .out_ready(out_ready),
    .out_cnt(out_cnt16), .out_acc(out_acc16), .out_last(out_last16), .out_ovf(out_ovf16)
  );

  popcount_accum #(.N(15), .ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid8), .out_ready(out_ready),
    .out_cnt(out_cnt8), .out_acc(out_acc8), .out_last(out_last8), .out_ovf(out_ovf8)
  );

  typedef struct {
    int   cnt;
    int   total;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  int   acc_log[$];
  int   frame_total = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_out = 0;
  logic fired = 1'b0;
  logic saw_stall = 1'b0;
  logic smp_in_ready = 1'b0;
  logic smp_out_valid = 1'b0;
  int   last_cnt16 = 0, last_acc16 = 0, last_acc8 = 0;
  logic last_last = 1'b0, last_ovf16 = 1'b0, last_ovf8 = 1'b0;

  function automatic int exp_acc(input int total, input int w);
    int max_v;
    max_v = (1 << w) - 1;
`ifdef POPCOUNT_ACCUM_SAT_EN
    return (total > max_v) ? max_v : total;
`else
    return total % (1 << w);
`endif
  endfunction

  function automatic logic exp_ovf(input int total, input int w);
    return total > ((1 << w) - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample and score at the falling edge, then advance past the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    smp_in_ready  = in_ready16;
    smp_out_valid = out_valid16;
    fired = 1'b0;
    if (!in_ready16) saw_stall = 1'b1;
    if (rst || clr) begin
      exp_q.delete();
      frame_total = 0;
    end else begin
      if (out_valid16 && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'(out_valid16), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("cnt", 32'(out_cnt16), e.cnt);
          chk("acc16", 32'(out_acc16), exp_acc(e.total, 16));
          chk("ovf16", 32'(out_ovf16), 32'(exp_ovf(e.total, 16)));
          chk("last", 32'(out_last16), 32'(e.last));
          chk("acc8", 32'(out_acc8), exp_acc(e.total, 8));
          chk("ovf8", 32'(out_ovf8), 32'(exp_ovf(e.total, 8)));
          last_cnt16 = out_cnt16; last_acc16 = out_acc16; last_acc8 = out_acc8;
          last_last = out_last16; last_ovf16 = out_ovf16; last_ovf8 = out_ovf8;
          acc_log.push_back(int'(out_acc16));
        end
      end
      if (in_valid && in_ready16) begin
        fired = 1'b1;
        e.cnt = $countones(in_data);
        frame_total += e.cnt;
        e.total = frame_total;
        e.last = in_last;
        exp_q.push_back(e);
        if (in_last) frame_total = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [14:0] data, input logic last);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    for (int i = 0; i < 20; i++) begin
      step();
      if (fired) break;
    end
    chk("accept", 32'(fired), 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && !out_valid16) break;
      step();
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq[4];
    int sent;
    int outs_before;

    // Reset held three cycles with a word offered.
    in_valid = 1'b1;
    in_data  = 15'h7FFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_in_ready", 32'(smp_in_ready), 32'd0);
    end
    chk("rst_out_valid", 32'(out_valid16), 32'd0);
    chk("rst_out_cnt", 32'(out_cnt16), 32'd0);
    chk("rst_out_acc", 32'(out_acc16), 32'd0);
    chk("rst_out_last", 32'(out_last16), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf16), 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 32'(smp_in_ready), 32'd1);

    // Single full word, last of its frame.
    drive_word(15'h7FFF, 1'b1);
    drain();
    chk("single_cnt", 32'(last_cnt16), 32'd15);
    chk("single_acc", 32'(last_acc16), 32'd15);
    chk("single_last", 32'(last_last), 32'd1);
    chk("single_ovf", 32'(last_ovf16), 32'd0);

    // Frame restart after a last word.
    acc_log.delete();
    drive_word(15'h0001, 1'b0);
    drive_word(15'h0003, 1'b0);
    drive_word(15'h7FFF, 1'b1);
    drive_word(15'h0005, 1'b0);
    drain();
    exp_seq = '{1, 3, 18, 2};
    chk("restart_count", 32'(acc_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++) chk("restart_acc", acc_log[i], exp_seq[i]);

    // clr with two words in flight.
    out_ready = 1'b0;
    outs_before = n_out;
    drive_word(15'h00FF, 1'b0);
    drive_word(15'h0F0F, 1'b1);
    clr = 1'b1;
    in_valid = 1'b1;
    in_data = 15'h7FFF;
    step();
    chk("clr_in_ready", 32'(smp_in_ready), 32'd0);
    clr = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("clr_out_valid", 32'(smp_out_valid), 32'd0);
    drive_word(15'h000F, 1'b1);
    drain();
    chk("clr_outputs", 32'(n_out - outs_before), 32'd1);
    chk("clr_acc", 32'(last_acc16), 32'd4);
    chk("clr_ovf", 32'(last_ovf16), 32'd0);

    // Overflow of the 8-bit accumulator: 18 x 15 = 270.
    for (int i = 0; i < 18; i++) drive_word(15'h7FFF, i == 17);
    drain();
`ifdef POPCOUNT_ACCUM_SAT_EN
    chk("ovf8_acc", 32'(last_acc8), 32'd255);
`else
    chk("ovf8_acc", 32'(last_acc8), 32'd14);
`endif
    chk("ovf8_flag", 32'(last_ovf8), 32'd1);
    chk("ovf16_acc", 32'(last_acc16), 32'd270);

    // Backpressure: 10 random words, out_ready low on stream cycles 3..6.
    saw_stall = 1'b0;
    outs_before = n_out;
    sent = 0;
    in_data = 15'($urandom);
    for (int cyc = 0; cyc < 100 && sent < 10; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid = 1'b1;
      in_last = (sent == 9);
      step();
      if (fired) begin
        sent++;
        in_data = 15'($urandom);
      end
    end
    in_last = 1'b0;
    drain();
    chk("bp_sent", 32'(sent), 32'd10);
    chk("bp_stall_seen", 32'(saw_stall), 32'd1);
    chk("bp_outputs", 32'(n_out - outs_before), 32'd10);

    // Random traffic with random backpressure and occasional clr.
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!in_valid || fired) begin
        in_data = 15'($urandom);
        in_last = ($urandom_range(0, 3) == 0);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 39) == 0);
      step();
    end
    clr = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
